// File: rtl/piso_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_stream_serializer
// Purpose  : Parallel-in / serial-out converter. Words arrive over a
//            valid/ready handshake into a one-word holding buffer. From there
//            they move into a shift register that drives a single registered
//            serial wire. The holding buffer refills while a word is shifting,
//            so consecutive words stream out with no idle bit between them.
// Ports    : CLK      - rising-edge clock
//            RESET    - asynchronous active-low reset
//            P_IN     - parallel word (WIDTH bits)
//            P_VALID  - producer has a word on P_IN
//            P_READY  - holding buffer empty, word accepted this cycle
//            S_EN     - shift enable, 0 freezes the serial side
//            S_OUT    - registered serial data
//            S_VALID  - S_OUT carries a word bit
//            S_FIRST  - S_OUT is the first emitted bit of a word
//            S_LAST   - S_OUT is the final emitted bit of a word
//            BUSY     - word held, shifting, or bit on S_OUT
// Revision : 1.0 - initial release
// ============================================================================
module piso_stream_serializer #(
    parameter int WIDTH      = 32,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] P_IN,
    input  logic             P_VALID,
    output logic             P_READY,
    input  logic             S_EN,
    output logic             S_OUT,
    output logic             S_VALID,
    output logic             S_FIRST,
    output logic             S_LAST,
    output logic             BUSY
);

    localparam int               c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Flops and their next-state values
    logic [WIDTH-1:0]   h_q, h_d;
    logic               h_full_q, h_full_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               s_out_q, s_out_d;
    logic               s_valid_q, s_valid_d;
    logic               s_first_q, s_first_d;
    logic               s_last_q, s_last_d;

    // Bit-order dependent views. The shift register always holds only the
    // bits still to be emitted, pre-shifted so the next one sits at the
    // output end; the bit placed on S_OUT is never kept in SR.
    logic               w_load_bit;
    logic [WIDTH-1:0]   w_load_sr;
    logic               w_shift_bit;
    logic [WIDTH-1:0]   w_shift_sr;
    logic               w_accept;

    if (MSB_FIRST) begin : g_msb_first
        assign w_load_bit  = h_q[WIDTH-1];
        assign w_load_sr   = {h_q[WIDTH-2:0], 1'b0};
        assign w_shift_bit = sr_q[WIDTH-1];
        assign w_shift_sr  = {sr_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
        assign w_load_bit  = h_q[0];
        assign w_load_sr   = {1'b0, h_q[WIDTH-1:1]};
        assign w_shift_bit = sr_q[0];
        assign w_shift_sr  = {1'b0, sr_q[WIDTH-1:1]};
    end

    // Ready depends only on state, never on P_VALID
    assign w_accept = P_VALID & ~h_full_q;

    always_comb begin
        h_d       = h_q;
        h_full_d  = h_full_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        s_out_d   = s_out_q;
        s_valid_d = s_valid_q;
        s_first_d = s_first_q;
        s_last_d  = s_last_q;

        // Serial side: everything holds while S_EN is low
        if (S_EN) begin
            if (cnt_q != '0) begin
                s_out_d   = w_shift_bit;
                sr_d      = w_shift_sr;
                cnt_d     = cnt_q - c_CNT_ONE;
                s_valid_d = 1'b1;
                s_first_d = 1'b0;
                s_last_d  = (cnt_q == c_CNT_ONE);
            end else if (h_full_q) begin
                s_out_d   = w_load_bit;
                sr_d      = w_load_sr;
                cnt_d     = c_CNT_LOAD;
                h_full_d  = 1'b0;
                s_valid_d = 1'b1;
                s_first_d = 1'b1;
                s_last_d  = 1'b0;
            end else begin
                s_out_d   = IDLE_LEVEL;
                s_valid_d = 1'b0;
                s_first_d = 1'b0;
                s_last_d  = 1'b0;
            end
        end

        // An accept needs an empty buffer and a drain needs a full one, so
        // this never overrides the drain above.
        if (w_accept) begin
            h_d      = P_IN;
            h_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            h_q       <= '0;
            h_full_q  <= 1'b0;
            sr_q      <= '0;
            cnt_q     <= '0;
            s_out_q   <= IDLE_LEVEL;
            s_valid_q <= 1'b0;
            s_first_q <= 1'b0;
            s_last_q  <= 1'b0;
        end else begin
            h_q       <= h_d;
            h_full_q  <= h_full_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            s_out_q   <= s_out_d;
            s_valid_q <= s_valid_d;
            s_first_q <= s_first_d;
            s_last_q  <= s_last_d;
        end
    end

    assign P_READY = ~h_full_q;
    assign S_OUT   = s_out_q;
    assign S_VALID = s_valid_q;
    assign S_FIRST = s_first_q;
    assign S_LAST  = s_last_q;
    assign BUSY    = h_full_q | (cnt_q != '0) | s_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_stream_serializer
// Purpose  : Self-checking bench. A 32-bit MSB-first instance is compared
//            every cycle against a reference model that keeps the pending
//            word and the remaining bits of the current word as a queue. An
//            8-bit LSB-first instance gets a short directed sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_stream_serializer;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [W-1:0]  p_in;
    logic          p_valid;
    logic          p_ready;
    logic          s_en;
    logic          s_out, s_valid, s_first, s_last, busy;

    logic [7:0]    p_in8;
    logic          p_valid8, p_ready8, s_en8;
    logic          s_out8, s_valid8, s_first8, s_last8, busy8;

    piso_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .CLK(clk), .RESET(rst_n), .P_IN(p_in), .P_VALID(p_valid), .P_READY(p_ready),
        .S_EN(s_en), .S_OUT(s_out), .S_VALID(s_valid), .S_FIRST(s_first),
        .S_LAST(s_last), .BUSY(busy)
    );

    piso_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut8 (
        .CLK(clk), .RESET(rst_n), .P_IN(p_in8), .P_VALID(p_valid8), .P_READY(p_ready8),
        .S_EN(s_en8), .S_OUT(s_out8), .S_VALID(s_valid8), .S_FIRST(s_first8),
        .S_LAST(s_last8), .BUSY(busy8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    bit         m_hfull;
    logic [W-1:0] m_h;
    bit         m_bits[$];   // bits still to emit after the one on S_OUT
    bit         m_out, m_valid, m_first, m_last;
    int         m_acc_cnt = 0;

    function automatic void model_reset();
        m_hfull = 1'b0;
        m_bits.delete();
        m_out   = 1'b0;
        m_valid = 1'b0;
        m_first = 1'b0;
        m_last  = 1'b0;
    endfunction

    function automatic void model_edge();
        bit acc;
        acc = p_valid && !m_hfull;
        if (s_en) begin
            if (m_bits.size() > 0) begin
                m_out   = m_bits.pop_front();
                m_valid = 1'b1;
                m_first = 1'b0;
                m_last  = (m_bits.size() == 0);
            end else if (m_hfull) begin
                m_bits.delete();
                for (int i = 0; i < W; i++) m_bits.push_back(m_h[W-1-i]);
                m_out   = m_bits.pop_front();
                m_valid = 1'b1;
                m_first = 1'b1;
                m_last  = 1'b0;
                m_hfull = 1'b0;
            end else begin
                m_out   = 1'b0;
                m_valid = 1'b0;
                m_first = 1'b0;
                m_last  = 1'b0;
            end
        end
        if (acc) begin
            m_h     = p_in;
            m_hfull = 1'b1;
            m_acc_cnt++;
        end
    endfunction

    task automatic check_all();
        chk("s_out",   s_out,   m_out);
        chk("s_valid", s_valid, m_valid);
        chk("s_first", s_first, m_first);
        chk("s_last",  s_last,  m_last);
        chk("p_ready", p_ready, !m_hfull);
        chk("busy",    busy,    m_hfull || (m_bits.size() != 0) || m_valid);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int acc0;
        logic [7:0] pat;

        rst_n = 1'b0; p_in = '0; p_valid = 1'b0; s_en = 1'b1;
        p_in8 = '0; p_valid8 = 1'b0; s_en8 = 1'b1;
        model_reset();
        #2;
        chk("rst_s_out",   s_out,   1'b0);
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_p_ready", p_ready, 1'b1);
        chk("rst_busy",    busy,    1'b0);
        chk("rst8_ready",  p_ready8, 1'b1);
        #1 rst_n = 1'b1;

        // Single word 0xA5A50F0F, first byte checked against a literal pattern
        pat = 8'hA5;
        p_valid = 1'b1; p_in = 32'hA5A50F0F;
        step();
        p_valid = 1'b0; p_in = $urandom;   // later P_IN changes must not matter
        for (int i = 0; i < 34; i++) begin
            step();
            if (i < 8) chk("a5_bit", s_out, pat[7-i]);
            if (i == 0)  chk("a5_first", s_first, 1'b1);
            if (i == 31) chk("a5_last",  s_last,  1'b1);
            if (i == 32) chk("a5_idle",  s_valid, 1'b0);
        end

        // Back-to-back words with an always-valid producer
        nv = 0;
        acc0 = m_acc_cnt;
        p_valid = 1'b1; p_in = 32'hFFFF0000;
        for (int i = 0; i < 80; i++) begin
            step();
            if (s_valid) nv++;
            if (m_acc_cnt == acc0 + 1) p_in = 32'h0000FFFF;
            if (m_acc_cnt >= acc0 + 2) p_valid = 1'b0;
        end
        chk("b2b_valid_cycles", nv, 64);

        // Shift pause after the fourth bit
        nv = 0;
        p_valid = 1'b1; p_in = 32'hF0F0F0F0;
        step();
        p_valid = 1'b0;
        for (int i = 0; i < 45; i++) begin
            s_en = !(i >= 4 && i < 9);
            step();
            if (s_valid) nv++;
        end
        s_en = 1'b1;
        chk("pause_word_cycles", nv, 37);

        // Asynchronous reset in the middle of a word
        p_valid = 1'b1; p_in = $urandom;
        step();
        p_valid = 1'b0;
        for (int i = 0; i < 11; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_s_out",   s_out,   1'b0);
        chk("mid_rst_s_valid", s_valid, 1'b0);
        chk("mid_rst_p_ready", p_ready, 1'b1);
        chk("mid_rst_busy",    busy,    1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        p_valid = 1'b1; p_in = 32'h12345678;
        step();
        p_valid = 1'b0;
        step();
        chk("post_rst_first", s_first, 1'b1);
        for (int i = 0; i < 34; i++) step();

        // 8-bit LSB-first instance, word 0x01
        p_valid8 = 1'b1; p_in8 = 8'h01;
        step();
        p_valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("w8_bit",   s_out8,   (i == 0) ? 1'b1 : 1'b0);
            chk("w8_valid", s_valid8, 1'b1);
            chk("w8_first", s_first8, (i == 0));
            chk("w8_last",  s_last8,  (i == 7));
        end
        step();
        chk("w8_idle_valid", s_valid8, 1'b0);
        chk("w8_idle_busy",  busy8,    1'b0);

        // Random traffic with a fast producer (hold buffer often full)
        for (int i = 0; i < 800; i++) begin
            s_en    = ($urandom_range(0, 7) != 0);
            p_valid = ($urandom_range(0, 3) != 0);
            p_in    = $urandom;
            step();
        end
        // Random traffic with sparse producer and frequent pauses
        for (int i = 0; i < 800; i++) begin
            s_en    = ($urandom_range(0, 2) != 0);
            p_valid = ($urandom_range(0, 15) == 0);
            p_in    = $urandom;
            step();
        end
        p_valid = 1'b0; s_en = 1'b1;
        for (int i = 0; i < 80; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_stream_serializer.md
Name: piso_stream_serializer

Overview:
Parametrised parallel-in/serial-out converter with a valid/ready handshake on the parallel side. It is the next generation of the team's 32-bit parallel-to-serial converter. A one-word holding buffer lets consecutive words stream out with no idle bit between them. It adds selectable bit order, a shift-enable pause, and first/last framing flags, and sits between a word-oriented producer and a single-wire serial link.

Parameters:
WIDTH, 32, parallel word width in bits; legal range 2..64
MSB_FIRST, 1, 1 = emit P_IN[WIDTH-1] first; 0 = emit P_IN[0] first
IDLE_LEVEL, 0, value driven on S_OUT while no bit is valid

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-low reset; block held in reset while 0
P_IN  input  WIDTH  parallel word
P_VALID  input  1  producer asserts when P_IN holds a word
P_READY  output  1  block can accept a word this cycle
S_EN  input  1  shift enable; 0 pauses the serial side
S_OUT  output  1  serial data, registered
S_VALID  output  1  S_OUT carries a word bit
S_FIRST  output  1  S_OUT is bit 0 of the emitted sequence of a word
S_LAST  output  1  S_OUT is the final bit of a word
BUSY  output  1  any word held, shifting, or bit on S_OUT

Behaviour:
- Reset (RESET=0, asynchronous): S_OUT=IDLE_LEVEL; S_VALID, S_FIRST and S_LAST are 0; hold buffer emptied (H_full=0); bit counter CNT=0; any partially shifted word is discarded. P_READY=1 and BUSY=0 immediately.
- Internal state:
  - hold register H plus flag H_full;
  - shift register SR;
  - CNT in 0..WIDTH-1, the number of bits remaining after the bit currently on S_OUT.
- P_READY = !H_full, combinational from state only, with no dependency on P_VALID.
- Accept: at a rising edge with P_VALID=1 and P_READY=1, H<=P_IN and H_full<=1. Acceptance is independent of S_EN.
- Serial side, evaluated at each rising edge with S_EN=1, first matching case wins:
  - a) CNT>0: S_OUT<=next bit of SR in the configured order; CNT<=CNT-1; S_VALID<=1; S_FIRST<=0; S_LAST<=(CNT==1).
  - b) CNT==0 and H_full: SR<=H; S_OUT<=first bit of H; CNT<=WIDTH-1; H_full<=0; S_VALID<=1; S_FIRST<=1; S_LAST<=0.
  - c) otherwise: S_OUT<=IDLE_LEVEL; S_VALID, S_FIRST and S_LAST <=0.
- S_EN=0: S_OUT, S_VALID, S_FIRST, S_LAST, SR and CNT all hold, so a paused bit stays on S_OUT. The hold buffer still accepts.
- Simultaneous events:
  - Case b and an accept cannot coincide, because an accept requires H_full=0 and case b requires H_full=1.
  - A word accepted at the same edge the hold buffer drains is impossible by the same rule. P_READY rises the cycle after the drain.
- Latency: a word accepted at edge k into an idle block puts its first bit on S_OUT after edge k+1, provided S_EN=1 at k+1.
  - Its last bit appears after edge k+WIDTH when S_EN is held high.
- Throughput: with S_EN held high and a producer that responds within WIDTH-1 cycles of P_READY, words stream gaplessly. S_VALID stays 1 across the word boundary, and S_LAST of word n is followed directly by S_FIRST of word n+1.
- BUSY = H_full | (CNT!=0) | S_VALID.
- P_IN is sampled only at the accept edge; later changes to P_IN have no effect on the word being shifted.

Test Plan:
- WIDTH=32, MSB_FIRST=1: accept 0xA5A50F0F at edge 0 with S_EN=1 -> S_OUT is 1,0,1,0,0,1,0,1,... after edges 1..32; S_FIRST only after edge 1, S_LAST only after edge 32; S_VALID=0 and S_OUT=0 after edge 33.
- Back-to-back 0xFFFF0000 then 0x0000FFFF, producer always valid -> S_VALID is 1 for exactly 64 consecutive cycles; S_LAST and S_FIRST are adjacent at bits 32 and 33; P_READY is 0 from the second accept until the second word is loaded.
- WIDTH=8, MSB_FIRST=0, word 0x01 -> first serial bit 1, then seven 0s; S_LAST on the eighth bit.
- S_EN dropped for 5 cycles after bit 3 of 0xF0F0F0F0 -> bit 3 is held on S_OUT for 6 cycles total, then the sequence resumes with bit 4; the total word spans 37 cycles.
- Hold buffer full while shifting, P_VALID=1 with 0x12345678 -> P_READY=0, no accept, and the word is accepted one cycle after the current word starts shifting.
- RESET pulled low mid-word after bit 10, between clock edges -> S_OUT=0 and S_VALID=0 immediately, P_READY=1, BUSY=0; after release, the next word starts at its first bit with S_FIRST=1.
